// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one registered full-adder step per clock,
// LSB first, with valid/ready handshakes on operands and result.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(WIDTH - 2);

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             cin_msb;

    logic             accept;
    logic             step;
    logic             last;
    logic             s_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] res_nxt;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

    assign accept  = in_ready & in_valid;
    assign step    = busy;
    assign last    = (cnt == LAST);

    // The single full-adder cell
    assign s_bit   = a_sh[0] ^ b_sh[0] ^ c;
    assign c_nxt   = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & c);
    assign res_nxt = {s_bit, res_sh[WIDTH-1:1]};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand shift registers, carry FF and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            cnt     <= '0;
            c       <= 1'b0;
            cin_msb <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= sub ? ~b : b;
            c    <= sub;
            cnt  <= '0;
        end else if (step) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt;
            c      <= c_nxt;
            cnt    <= cnt + 1'b1;
            if (cnt == PRE) cin_msb <= c_nxt;
        end
    end

    // Result registers only move on the final bit step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (step && last) begin
            sum       <= res_nxt;
            carry_out <= c_nxt;
            overflow  <= c_nxt ^ cin_msb;
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH=8 and WIDTH=16:
// directed vector table, handshake/reset sequences and random ops.
module tb_serial_addsub;

    logic        clk;
    logic        rst;
    logic        in_valid8, in_valid16;
    logic        out_ready;
    logic [31:0] a_in, b_in;
    logic        sub_in;

    logic        in_ready8, out_valid8, co8, ov8, busy8;
    logic [7:0]  sum8;
    logic        in_ready16, out_valid16, co16, ov16, busy16;
    logic [15:0] sum16;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a_in[7:0]), .b(b_in[7:0]), .sub(sub_in),
        .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .carry_out(co8), .overflow(ov8), .busy(busy8)
    );

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a_in[15:0]), .b(b_in[15:0]), .sub(sub_in),
        .out_valid(out_valid16), .out_ready(out_ready),
        .sum(sum16), .carry_out(co16), .overflow(ov16), .busy(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] e_sum;
        logic        e_co;
        logic        e_ov;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic rd_ready(input int w);
        return (w == 8) ? in_ready8 : in_ready16;
    endfunction
    function automatic logic rd_valid(input int w);
        return (w == 8) ? out_valid8 : out_valid16;
    endfunction
    function automatic logic rd_busy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction
    function automatic logic [31:0] rd_sum(input int w);
        return (w == 8) ? {24'd0, sum8} : {16'd0, sum16};
    endfunction
    function automatic logic rd_co(input int w);
        return (w == 8) ? co8 : co16;
    endfunction
    function automatic logic rd_ov(input int w);
        return (w == 8) ? ov8 : ov16;
    endfunction

    task automatic set_valid(input int w, input logic v);
        if (w == 8) in_valid8 = v;
        else        in_valid16 = v;
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views
    task automatic ref_model(input int w, input logic [31:0] a,
                             input logic [31:0] b, input logic s,
                             output logic [31:0] e_sum,
                             output logic e_co, output logic e_ov);
        longint m, ua, ub, sa, sb, r, half;
        m    = longint'(1) << w;
        half = m / 2;
        ua   = longint'(a) % m;
        ub   = longint'(b) % m;
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        if (s) begin
            e_sum = 32'((ua - ub + m) % m);
            e_co  = (ua >= ub);
            r     = sa - sb;
        end else begin
            e_sum = 32'((ua + ub) % m);
            e_co  = (ua + ub >= m);
            r     = sa + sb;
        end
        e_ov = (r >= half) || (r < -half);
    endtask

    // Offer one operation, then wait for out_valid (bounded)
    task automatic do_op(input int w, input logic [31:0] a,
                         input logic [31:0] b, input logic s,
                         output int lat, output int bz);
        @(negedge clk);
        a_in   = a;
        b_in   = b;
        sub_in = s;
        set_valid(w, 1'b1);
        check("accept_ready", 32'(rd_ready(w)), 32'd1);
        @(posedge clk);
        #1;
        set_valid(w, 1'b0);
        a_in = $urandom;
        b_in = $urandom;
        lat  = 0;
        bz   = 0;
        while (!rd_valid(w) && lat < 100) begin
            if (rd_busy(w)) bz++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rd_valid(w)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: out_valid got 0 want 1");
        end
    endtask

    task automatic run_check(input string tag, input int w,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic [31:0] e_sum,
                             input logic e_co, input logic e_ov);
        int lat, bz;
        do_op(w, a, b, s, lat, bz);
        check({tag, "_sum"}, rd_sum(w), e_sum);
        check({tag, "_co"}, 32'(rd_co(w)), 32'(e_co));
        check({tag, "_ov"}, 32'(rd_ov(w)), 32'(e_ov));
        check({tag, "_lat"}, 32'(lat), 32'(w));
        check({tag, "_busy"}, 32'(bz), 32'(w));
        @(posedge clk);
        #1;
        check({tag, "_ret_idle"}, 32'(rd_ready(w)), 32'd1);
    endtask

    initial begin
        int lat, bz, seen;
        logic [31:0] es;
        logic eco, eov;

        rst = 1'b1;
        in_valid8 = 1'b0;
        in_valid16 = 1'b0;
        out_ready = 1'b1;
        a_in = '0;
        b_in = '0;
        sub_in = 1'b0;

        vecs.push_back('{8, 32'h35, 32'h4A, 1'b0, 32'h7F, 1'b0, 1'b0});
        vecs.push_back('{8, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0});
        vecs.push_back('{8, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1});
        vecs.push_back('{8, 32'h10, 32'h20, 1'b1, 32'hF0, 1'b0, 1'b0});
        vecs.push_back('{8, 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1});
        vecs.push_back('{8, 32'h12, 32'h34, 1'b0, 32'h46, 1'b0, 1'b0});
        vecs.push_back('{16, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0});
        vecs.push_back('{16, 32'h1234, 32'h4321, 1'b0, 32'h5555, 1'b0, 1'b0});
        vecs.push_back('{16, 32'h8000, 32'h0001, 1'b1, 32'h7FFF, 1'b1, 1'b1});
        vecs.push_back('{16, 32'h0000, 32'h0001, 1'b1, 32'hFFFF, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        foreach (vecs[k]) begin
            int w;
            w = vecs[k].w;
            if (k == 0 || vecs[k-1].w != w) begin
                check("rst_sum", rd_sum(w), 32'd0);
                check("rst_co", 32'(rd_co(w)), 32'd0);
                check("rst_ov", 32'(rd_ov(w)), 32'd0);
                check("rst_valid", 32'(rd_valid(w)), 32'd0);
                check("rst_busy", 32'(rd_busy(w)), 32'd0);
                check("rst_ready", 32'(rd_ready(w)), 32'd1);
            end
        end

        for (int k = 0; k < vecs.size(); k++)
            run_check($sformatf("vec%0d", k), vecs[k].w, vecs[k].a,
                      vecs[k].b, vecs[k].s, vecs[k].e_sum,
                      vecs[k].e_co, vecs[k].e_ov);

        // Backpressure: stall in DONE while offering new operands
        out_ready = 1'b0;
        do_op(8, 32'h35, 32'h4A, 1'b0, lat, bz);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid8 = i[0] ? 1'b0 : 1'b1;
            a_in = $urandom;
            b_in = $urandom;
            sub_in = 1'($urandom);
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid8), 32'd1);
            check("bp_ready", 32'(in_ready8), 32'd0);
            check("bp_sum", 32'(sum8), 32'h7F);
            check("bp_co", 32'(co8), 32'd0);
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid8), 32'd0);
        check("bp_release_ready", 32'(in_ready8), 32'd1);
        check("bp_release_sum", 32'(sum8), 32'h7F);
        run_check("bp_next", 8, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0);

        // Reset after three RUN edges aborts the operation
        @(negedge clk);
        a_in = 32'h12;
        b_in = 32'h34;
        sub_in = 1'b0;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy8), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_ready", 32'(in_ready8), 32'd1);
        check("abort_busy", 32'(busy8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid8) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_idle", 32'(in_ready8), 32'd1);
        run_check("abort_next", 8, 32'h12, 32'h34, 1'b0, 32'h46, 1'b0, 1'b0);

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            int w;
            logic [31:0] ra, rb;
            logic rs;
            w  = (i % 3 == 2) ? 16 : 8;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            ref_model(w, ra, rb, rs, es, eco, eov);
            run_check($sformatf("rnd%0d", i), w, ra, rb, rs, es, eco, eov);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor.
- Built around a single registered full-adder cell with a carry flip-flop.
- Accepts two WIDTH-bit operands through a valid/ready handshake and processes one bit per clock, LSB first.
- Presents the registered sum, carry/borrow and signed overflow through a second valid/ready handshake. Intended as the area-cheap arithmetic element for counter/accumulator datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit counter width; derived, not to be overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands a, b, sub valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B, 1: A-B (two's complement).
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- carry_out  output  1  final carry; on subtract, 1 = no borrow (A >= B unsigned).
- overflow  output  1  signed overflow of the operation.
- busy  output  1  high in RUN.

Behaviour:
- Reset: the clock is clk; rst is asynchronous and active-high.
  - Asserting rst immediately forces state=IDLE and clears every register: sum=0, carry_out=0, overflow=0, out_valid=0, busy=0, bit counter=0, carry FF=0.
  - in_ready=1 while in IDLE after reset.
  - Reset mid-RUN or mid-DONE aborts the operation; no result is produced.
- States: IDLE, RUN, DONE. Outputs in_ready, busy and out_valid are pure decodes of the state register.
- IDLE:
  - On an edge with in_valid=1, latch A into the A shift register.
  - Latch B, or ~B when sub=1, into the B shift register.
  - Load carry FF with sub and clear the counter, then go to RUN.
  - in_valid=0 keeps the block in IDLE.
- RUN, one edge per bit i = 0..WIDTH-1:
  - s = A[0]^B[0]^c.
  - c_next = (A[0]&B[0]) | ((A[0]^B[0])&c).
  - Shift A and B right by one.
  - Shift s into the MSB of the internal result shift register.
  - counter++.
  - At i = WIDTH-2, capture c_next as cin_msb (the carry into the MSB).
  - At i = WIDTH-1:
    - load sum with the completed result register;
    - carry_out = c_next;
    - overflow = c_next ^ cin_msb;
    - go to DONE.
- Latency: operands accepted at edge E0; out_valid=1 in the cycle following edge E(WIDTH), i.e. exactly WIDTH cycles after acceptance.
- DONE:
  - out_valid=1; sum, carry_out and overflow are held stable.
  - On an edge with out_ready=1, go to IDLE; in_ready rises the following cycle (no same-cycle accept; throughput = one result per WIDTH+2 cycles minimum).
  - out_ready=0 stalls indefinitely with outputs stable.
- Handshake rules:
  - in_valid while in_ready=0 is ignored and has no side effects.
  - a, b and sub are sampled only on the accept edge; later changes are irrelevant.
  - out_ready outside DONE is ignored.
- Output registers (sum, carry_out, overflow) change only on the final bit step or on reset. They retain the last result through IDLE and RUN of the next operation.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- Reset then idle: assert rst for 3 cycles, release -> sum=0x00, carry_out=0, overflow=0, out_valid=0, busy=0, in_ready=1.
- WIDTH=8, add 0x35+0x4A, out_ready=1 -> out_valid exactly 8 cycles after accept edge, sum=0x7F, carry_out=0, overflow=0; busy high for 8 cycles.
- Add 0xFF+0x01 -> sum=0x00, carry_out=1, overflow=0; add 0x7F+0x01 -> sum=0x80, carry_out=0, overflow=1.
- Subtract 0x10-0x20 -> sum=0xF0, carry_out=0 (borrow), overflow=0; subtract 0x80-0x01 -> sum=0x7F, carry_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle in_valid with new operands -> outputs unchanged, in_ready=0, new operands not taken. Raise out_ready -> IDLE next cycle, then the next accept works.
- Reset mid-operation: start 0x12+0x34, assert rst after 3 RUN edges -> out_valid never rises, state IDLE, sum=0. A subsequent 0x12+0x34 -> sum=0x46. Repeat the adds with WIDTH=16: 0xFFFF+0x0001 -> 0x0000, carry_out=1, latency 16.
